workout_countdown_timer: RTL

- Downstream stage of the exercise calculator; loads its 9-bit total-minutes result (0..511) and counts it down as mm:ss in real time.
- Provides start, pause and clear control, a per-second tick, and a completion indication to the display and buzzer logic.
- All outputs are registered. One clock domain.

---
 rtl/workout_timer_pkg.sv | 16 +
 rtl/sec_prescaler.sv | 37 +++
 rtl/workout_countdown_timer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/workout_timer_pkg.sv
// Shared types and widths for the workout countdown timer.
package workout_timer_pkg;

  localparam int MIN_W           = 9;
  localparam int SEC_W           = 6;
  localparam int DEF_SEC_PER_MIN = 60;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-cycle tick every SEC_DIV enabled cycles.
module sec_prescaler #(
  parameter int SEC_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SEC_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // tick is combinational so the owner can act on the same edge the counter wraps
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/workout_countdown_timer.sv
// mm:ss countdown with start/pause/clear; optional warn output under WORKOUT_TIMER_WARN_EN.
module workout_countdown_timer
  import workout_timer_pkg::*;
#(
  parameter int SEC_DIV     = 50000000,
  parameter int SEC_PER_MIN = DEF_SEC_PER_MIN
`ifdef WORKOUT_TIMER_WARN_EN
  ,
  parameter int WARN_SECS   = 10
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MIN_W-1:0] load_min,
  input  logic             load,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  output logic [MIN_W-1:0] min_left,
  output logic [SEC_W-1:0] sec_left,
  output logic             running,
  output logic             paused,
  output logic             sec_tick,
  output logic             done,
  output logic             done_pulse
`ifdef WORKOUT_TIMER_WARN_EN
  ,
  output logic             warn
`endif
);

  state_e           state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             tick_q, tick_d;
  logic             done_pulse_q, done_pulse_d;
  logic             running_q, paused_q, done_q;
  logic             pre_clr, pre_en, pre_tick;

  sec_prescaler #(
    .SEC_DIV(SEC_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (pre_tick)
  );

  // Priority chain: clear > load > start > pause, then normal counting in RUN.
  always_comb begin
    state_d      = state_q;
    min_d        = min_q;
    sec_d        = sec_q;
    tick_d       = 1'b0;
    done_pulse_d = 1'b0;
    pre_clr      = 1'b0;
    pre_en       = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      min_d   = '0;
      sec_d   = '0;
      pre_clr = 1'b1;
    end else if (load && state_q != ST_RUN) begin
      state_d = ST_LOADED;
      min_d   = load_min;
      sec_d   = '0;
      pre_clr = 1'b1;
    end else if (start && state_q == ST_LOADED) begin
      pre_clr = 1'b1;
      if (min_q == '0 && sec_q == '0) begin
        state_d      = ST_DONE;
        done_pulse_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (start && state_q == ST_PAUSE) begin
      state_d = ST_RUN;
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (state_q == ST_RUN) begin
      pre_en = 1'b1;
      if (pre_tick) begin
        tick_d = 1'b1;
        if (sec_q != '0) begin
          sec_d = sec_q - 1'b1;
        end else if (min_q != '0) begin
          min_d = min_q - 1'b1;
          sec_d = SEC_W'(SEC_PER_MIN - 1);
        end
        if (min_d == '0 && sec_d == '0) begin
          state_d      = ST_DONE;
          done_pulse_d = 1'b1;
        end
      end
    end
  end

`ifdef WORKOUT_TIMER_WARN_EN
  logic warn_q, warn_d;

  always_comb begin
    warn_d = done_pulse_d ||
             (tick_d && min_d == '0 && sec_d != '0 && int'(sec_d) <= WARN_SECS);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      min_q        <= '0;
      sec_q        <= '0;
      tick_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      running_q    <= 1'b0;
      paused_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      tick_q       <= tick_d;
      done_pulse_q <= done_pulse_d;
      running_q    <= (state_d == ST_RUN);
      paused_q     <= (state_d == ST_PAUSE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign min_left   = min_q;
  assign sec_left   = sec_q;
  assign running    = running_q;
  assign paused     = paused_q;
  assign sec_tick   = tick_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;

endmodule
